// File: rtl/sync_up_counter.sv
// Synchronous binary up counter: counts 0..MAX and wraps to 0, with enable,
// synchronous parallel load, a combinational cascade terminal count and a one-cycle wrap pulse.
module sync_up_counter #(
    parameter int WIDTH = 4,
    parameter int MAX   = (2 ** WIDTH) - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] loadVal,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             wrapped
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] out_r;
    logic [WIDTH-1:0] out_next_s;
    logic             wrapped_r;
    logic             wrapped_next_s;
    logic             terminal_s;

    // An out-of-range loaded value is treated as terminal so it wraps instead of counting past MAX.
    assign terminal_s = (out_r >= MAX_V);

    // Next-state selection: load beats enable, enable either steps or wraps.
    always_comb begin
        out_next_s     = out_r;
        wrapped_next_s = 1'b0;
        if (load) begin
            out_next_s     = loadVal;
            wrapped_next_s = 1'b0;
        end else if (en) begin
            if (terminal_s) begin
                out_next_s     = {WIDTH{1'b0}};
                wrapped_next_s = 1'b1;
            end else begin
                out_next_s     = out_r + WIDTH'(1);
                wrapped_next_s = 1'b0;
            end
        end else begin
            out_next_s     = out_r;
            wrapped_next_s = 1'b0;
        end
    end

    // Count and wrap-flag registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_r     <= {WIDTH{1'b0}};
            wrapped_r <= 1'b0;
        end else begin
            out_r     <= out_next_s;
            wrapped_r <= wrapped_next_s;
        end
    end

    assign out     = out_r;
    assign wrapped = wrapped_r;
    assign tc      = en & terminal_s;

endmodule

// File: doc/sync_up_counter.md
# sync_up_counter

Synchronous binary up counter, the counting-direction complement of the lab's synchronous down counter. Counts 0 → MAX, wraps to 0, and supports an enable, a synchronous parallel load, and a terminal-count output so several instances cascade into wider counters. Paired with the down counter it gives the lab both count directions on the same clock/reset scheme. Used as a standalone counter and as the building block for multi-digit up counters.

## Interface

Parameters:
- WIDTH, 4, counter width in bits.
- MAX, 2**WIDTH-1 (15), terminal value; legal range 1..2**WIDTH-1.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  asynchronous reset, active-high.
- en  input  1  count enable; advance by one on a rising clk edge when high.
- load  input  1  synchronous parallel load; overrides en.
- loadVal  input  WIDTH  value captured on load.
- out  output  WIDTH  current count, registered.
- tc  output  1  terminal count, combinational: en & (out >= MAX); cascade enable for the next stage.
- wrapped  output  1  registered one-cycle pulse, high in the cycle after out wrapped to 0.

## Operation

- The design is one WIDTH-bit state register, out, plus one flag register, wrapped.
- Priority on each rising clk edge, highest first:
  - rst: asynchronous, acts regardless of clk.
  - load: out ← loadVal, wrapped ← 0.
  - en: if out >= MAX, out ← 0 and wrapped ← 1. Otherwise out ← out + 1 and wrapped ← 0.
  - Otherwise: out holds, wrapped ← 0.
- Arithmetic is unsigned, modulo 2**WIDTH. No overflow state exists beyond the wrap to 0.
- Out-of-range load (loadVal > MAX): the value is accepted as-is. It counts as terminal, so the next enabled edge sends out to 0 with wrapped = 1. The counter never counts upward past MAX from such a value.
- tc goes high in the same cycle that out = MAX (or above) while en is high. It is deasserted whenever en is low.
- Cascading: drive stage N+1's en from stage N's tc. The combined count is then an exact product-modulus counter, for example two 4-bit stages give 0..255.
- load while out = MAX and en = 1: the load wins, there is no wrap, and wrapped stays 0. tc is still high combinationally before the edge.

## Timing

- Reset: out = 0 and wrapped = 0, asynchronously. tc = 0 during and after reset until out reaches MAX with en high.
- Releasing rst takes effect at the first rising edge after deassertion. No count occurs on an edge where rst is still high.
- Latency:
  - en to out change: 1 clk edge.
  - load to out = loadVal: 1 edge.
  - Wrap edge to wrapped pulse: the same edge, visible for exactly one cycle.
  - tc: zero cycles, combinational from out and en.
- If rst asserts mid-count, out goes to 0 immediately without waiting for clk, and any in-progress wrapped pulse is cleared.
- en toggling between edges has no effect. Only the value sampled at the rising edge matters.
- A counter with en held high has period MAX+1 cycles: wrapped pulses every MAX+1 cycles and tc is high 1 of every MAX+1 cycles.

## Test plan

- Reset and free run (WIDTH 4, MAX 15):
  - Stimulus: assert rst, then hold en = 1 for 20 edges.
  - Required response: out reads 0 right after rst. It then steps 1, 2 … 15, 0, 1 … 4. tc is high only while out = 15. wrapped is high for exactly the one cycle after 15 → 0.
- Enable gating:
  - Stimulus: set en = 0 for 3 edges at out = 6, then en = 1.
  - Required response: out holds 6 for 3 cycles, then reads 7. tc and wrapped stay 0.
- Load priority:
  - Stimulus: at out = 15 with en = 1, assert load with loadVal = 9.
  - Required response: the next out is 9 and wrapped = 0. Then 10, 11 … with en.
- Out-of-range load and modulus (MAX 9):
  - Stimulus 1: from reset with en = 1.
  - Required response: out cycles 0..9. wrapped pulses every 10 cycles.
  - Stimulus 2: loadVal = 13, then en = 1.
  - Required response: tc = 1 immediately; the next out is 0 with wrapped = 1.
- Asynchronous reset mid-operation:
  - Stimulus: at out = 11, pulse rst between clk edges.
  - Required response: out becomes 0 before the next edge. Counting resumes 1, 2 … after release.
- Cascade:
  - Stimulus: two instances, the upper stage's en driven by the lower stage's tc, en = 1 on the lower stage for 256 edges.
  - Required response: the concatenated {upper, lower} counts 0..255 and returns to 0. The upper stage's wrapped fires once, on the 255 → 0 edge.
